// File: rtl/regfile_mp_sb_pkg.sv
// Shared widths, default sizes and register-file typedefs for the
// multi-port register file and its scoreboard.
package regfile_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;

    function automatic int aw(input int nregs);
        return $clog2(nregs);
    endfunction

    function automatic int cw(input int nregs);
        return $clog2(nregs + 1);
    endfunction

    typedef logic [aw(NREGS_DEF)-1:0] reg_addr_t;
    typedef logic [XLEN_DEF-1:0]      reg_data_t;

endpackage

// File: rtl/regfile_mp_sb_if.sv
// Bus bundle for the register file: write-back, read, issue and flush.
interface regfile_mp_sb_if
    import regfile_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int NREGS = NREGS_DEF,
    parameter int NRD   = 2
);
    localparam int AW = aw(NREGS);
    localparam int CW = cw(NREGS);

    logic                          we0;
    logic [AW-1:0]                 waddr0;
    logic [XLEN-1:0]               wdata0;
    logic                          we1;
    logic [AW-1:0]                 waddr1;
    logic [XLEN-1:0]               wdata1;
    logic [NRD-1:0][AW-1:0]        raddr;
    logic [NRD-1:0][XLEN-1:0]      rdata;
    logic [NRD-1:0]                rbusy;
    logic                          iss_valid;
    logic [AW-1:0]                 iss_rd;
    logic                          flush;
    logic [CW-1:0]                 busy_cnt;

    modport master (
        output we0, waddr0, wdata0, we1, waddr1, wdata1, raddr,
        output iss_valid, iss_rd, flush,
        input  rdata, rbusy, busy_cnt
    );

    modport slave (
        input  we0, waddr0, wdata0, we1, waddr1, wdata1, raddr,
        input  iss_valid, iss_rd, flush,
        output rdata, rbusy, busy_cnt
    );
endinterface

// File: rtl/regfile_mp_sb_scoreboard.sv
// Busy-bit scoreboard: clear on write-back, set on issue (set wins),
// flush clears everything; busy_cnt tracks the population count.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int NREGS = NREGS_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   set_en,
    input  logic [aw(NREGS)-1:0]   set_idx,
    input  logic                   clr0_en,
    input  logic [aw(NREGS)-1:0]   clr0_idx,
    input  logic                   clr1_en,
    input  logic [aw(NREGS)-1:0]   clr1_idx,
    input  logic                   flush,
    output logic [NREGS-1:0]       busy,
    output logic [cw(NREGS)-1:0]   busy_cnt
);
    localparam int CW = cw(NREGS);

    logic [NREGS-1:0] busy_nxt;

    function automatic logic [CW-1:0] popcount(input logic [NREGS-1:0] v);
        logic [CW-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < NREGS; i++) begin
            cnt = cnt + CW'(v[i]);
        end
        return cnt;
    endfunction

    // Later assignments take priority: clear < set < flush.
    always_comb begin
        busy_nxt = busy;
        if (clr0_en) busy_nxt[clr0_idx] = 1'b0;
        if (clr1_en) busy_nxt[clr1_idx] = 1'b0;
        if (set_en)  busy_nxt[set_idx]  = 1'b1;
        if (flush)   busy_nxt           = '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy     <= '0;
            busy_cnt <= '0;
        end else begin
            busy     <= busy_nxt;
            busy_cnt <= popcount(busy_nxt);
        end
    end

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-port register file: two write-back ports (port 1 wins), NRD
// combinational read ports with optional write bypass, busy scoreboard.
module regfile_mp_sb
    import regfile_pkg::*;
#(
    parameter int XLEN     = XLEN_DEF,
    parameter int NREGS    = NREGS_DEF,
    parameter int NRD      = 2,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1
) (
    input  logic           clk,
    input  logic           rst,
    regfile_mp_sb_if.slave bus
);
    localparam int AW = aw(NREGS);
    localparam int CW = cw(NREGS);

    if ((1 << AW) != NREGS) begin : g_nregs_check
        $error("regfile_mp_sb: NREGS must be a power of two");
    end
    if (NRD < 1 || NRD > 4) begin : g_nrd_check
        $error("regfile_mp_sb: NRD must be in 1..4");
    end

    logic [XLEN-1:0]          regs [NREGS];
    logic                     wr0_en, wr1_en, set_en;
    logic [NREGS-1:0]         busy;
    logic [CW-1:0]            busy_cnt;
    logic [NRD-1:0][XLEN-1:0] rd_val;
    logic [NRD-1:0]           rb_val;

    // Writes and issues to a hardwired-zero r0 are dropped at the source.
    assign wr0_en = bus.we0 && !(ZERO_REG && bus.waddr0 == '0);
    assign wr1_en = bus.we1 && !(ZERO_REG && bus.waddr1 == '0);
    assign set_en = bus.iss_valid && !(ZERO_REG && bus.iss_rd == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else begin
            if (wr0_en) regs[bus.waddr0] <= bus.wdata0;
            if (wr1_en) regs[bus.waddr1] <= bus.wdata1;
        end
    end

    regfile_scoreboard #(.NREGS(NREGS)) u_sb (
        .clk      (clk),
        .rst      (rst),
        .set_en   (set_en),
        .set_idx  (bus.iss_rd),
        .clr0_en  (wr0_en),
        .clr0_idx (bus.waddr0),
        .clr1_en  (wr1_en),
        .clr1_idx (bus.waddr1),
        .flush    (bus.flush),
        .busy     (busy),
        .busy_cnt (busy_cnt)
    );

    always_comb begin
        rd_val = '0;
        rb_val = '0;
        for (int i = 0; i < NRD; i++) begin
            logic [AW-1:0] a;
            logic          hit0, hit1;
            a    = bus.raddr[i];
            hit0 = wr0_en && (bus.waddr0 == a);
            hit1 = wr1_en && (bus.waddr1 == a);
            rd_val[i] = regs[a];
            rb_val[i] = busy[a];
            if (BYPASS) begin
                if (hit1)      rd_val[i] = bus.wdata1;
                else if (hit0) rd_val[i] = bus.wdata0;
                // A retiring producer hides busy unless a new one issues now.
                if ((hit0 || hit1) && !(set_en && bus.iss_rd == a)) rb_val[i] = 1'b0;
            end
            if (ZERO_REG && a == '0) rd_val[i] = '0;
            if (!rst) begin
                rd_val[i] = '0;
                rb_val[i] = 1'b0;
            end
        end
    end

    assign bus.rdata    = rd_val;
    assign bus.rbusy    = rb_val;
    assign bus.busy_cnt = busy_cnt;

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Bench for regfile_mp_sb: directed vector table, flush/saturation/reset
// sequences, then random traffic against an array-based reference model.
module tb_regfile_mp_sb;
    import regfile_pkg::*;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int NRD   = 2;
    localparam int AW    = 5;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    regfile_mp_sb_if #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) bus ();
    regfile_mp_sb_if #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) bus_nb ();

    regfile_mp_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .ZERO_REG(1'b1), .BYPASS(1'b1))
        dut (.clk(clk), .rst(rst), .bus(bus));
    regfile_mp_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .ZERO_REG(1'b1), .BYPASS(1'b0))
        dut_nb (.clk(clk), .rst(rst), .bus(bus_nb));

    assign bus_nb.we0       = bus.we0;
    assign bus_nb.waddr0    = bus.waddr0;
    assign bus_nb.wdata0    = bus.wdata0;
    assign bus_nb.we1       = bus.we1;
    assign bus_nb.waddr1    = bus.waddr1;
    assign bus_nb.wdata1    = bus.wdata1;
    assign bus_nb.raddr     = bus.raddr;
    assign bus_nb.iss_valid = bus.iss_valid;
    assign bus_nb.iss_rd    = bus.iss_rd;
    assign bus_nb.flush     = bus.flush;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: architectural contents and busy flags.
    logic [XLEN-1:0] mreg  [NREGS];
    bit              mbusy [NREGS];

    task automatic m_reset();
        for (int i = 0; i < NREGS; i++) begin
            mreg[i]  = '0;
            mbusy[i] = 1'b0;
        end
    endtask

    task automatic m_edge();
        if (bus.we0 && bus.waddr0 != 0) mreg[bus.waddr0] = bus.wdata0;
        if (bus.we1 && bus.waddr1 != 0) mreg[bus.waddr1] = bus.wdata1;
        if (bus.we0) mbusy[bus.waddr0] = 1'b0;
        if (bus.we1) mbusy[bus.waddr1] = 1'b0;
        if (bus.iss_valid && bus.iss_rd != 0) mbusy[bus.iss_rd] = 1'b1;
        if (bus.flush) for (int i = 0; i < NREGS; i++) mbusy[i] = 1'b0;
        mbusy[0] = 1'b0;
    endtask

    function automatic int m_cnt();
        int n = 0;
        for (int i = 0; i < NREGS; i++) n += int'(mbusy[i]);
        return n;
    endfunction

    function automatic logic [XLEN-1:0] m_read(input logic [AW-1:0] a, input bit bp);
        if (a == 0) return '0;
        if (bp && bus.we1 && bus.waddr1 == a) return bus.wdata1;
        if (bp && bus.we0 && bus.waddr0 == a) return bus.wdata0;
        return mreg[a];
    endfunction

    function automatic bit m_rbusy(input logic [AW-1:0] a, input bit bp);
        bit written, issued;
        written = (bus.we0 && bus.waddr0 == a) || (bus.we1 && bus.waddr1 == a);
        issued  = bus.iss_valid && bus.iss_rd == a;
        if (bp && written && !issued) return 1'b0;
        return mbusy[a];
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic idle();
        bus.we0 = 0; bus.waddr0 = '0; bus.wdata0 = '0;
        bus.we1 = 0; bus.waddr1 = '0; bus.wdata1 = '0;
        bus.iss_valid = 0; bus.iss_rd = '0; bus.flush = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        m_edge();
        @(negedge clk);
    endtask

    typedef struct {
        logic we0; logic [AW-1:0] wa0; logic [31:0] wd0;
        logic we1; logic [AW-1:0] wa1; logic [31:0] wd1;
        logic [AW-1:0] ra0; logic [AW-1:0] ra1;
        logic iv; logic [AW-1:0] ird; logic fl;
        logic [31:0] e_rd0; logic [31:0] e_rd1; logic [31:0] e_rd0_nb;
        logic e_rb0; logic e_rb0_nb; logic [5:0] e_cnt;
    } vec_t;

    vec_t vt [16];

    initial begin
        checks = 0; failures = 0;
        idle();
        m_reset();
        rst = 0;
        bus.we1 = 1; bus.waddr1 = 5'd3; bus.wdata1 = 32'h1234;
        bus.raddr[0] = 5'd3; bus.raddr[1] = 5'd3;
        #1;
        chk("reset_rdata0", bus.rdata[0], 0);
        chk("reset_rdata1", bus.rdata[1], 0);
        chk("reset_rbusy", bus.rbusy, 0);
        chk("reset_cnt", bus.busy_cnt, 0);
        idle();
        @(negedge clk); @(negedge clk);
        rst = 1;

        //      we0 wa0 wd0          we1 wa1 wd1     ra0 ra1 iv ird fl  rd0   rd1   rd0nb rb rbnb cnt
        vt[0]  = '{1, 3, 32'h11,      0, 0, 0,         3, 4, 0, 0, 0, 32'h11, 0,      0,      0, 0, 0};
        vt[1]  = '{0, 0, 0,           1, 4, 32'h22,    3, 4, 0, 0, 0, 32'h11, 32'h22, 32'h11, 0, 0, 0};
        vt[2]  = '{0, 0, 0,           0, 0, 0,         3, 4, 0, 0, 0, 32'h11, 32'h22, 32'h11, 0, 0, 0};
        vt[3]  = '{1, 0, 32'hFFFFFFFF, 0, 0, 0,        0, 3, 0, 0, 0, 0,      32'h11, 0,      0, 0, 0};
        vt[4]  = '{0, 0, 0,           0, 0, 0,         0, 4, 0, 0, 0, 0,      32'h22, 0,      0, 0, 0};
        vt[5]  = '{1, 7, 32'hA,       1, 7, 32'hB,     7, 3, 0, 0, 0, 32'hB,  32'h11, 0,      0, 0, 0};
        vt[6]  = '{0, 0, 0,           0, 0, 0,         7, 4, 0, 0, 0, 32'hB,  32'h22, 32'hB,  0, 0, 0};
        vt[7]  = '{0, 0, 0,           0, 0, 0,         9, 7, 1, 9, 0, 0,      32'hB,  0,      0, 0, 1};
        vt[8]  = '{0, 0, 0,           0, 0, 0,         9, 7, 0, 0, 0, 0,      32'hB,  0,      1, 1, 1};
        vt[9]  = '{1, 9, 32'h99,      0, 0, 0,         9, 3, 0, 0, 0, 32'h99, 32'h11, 0,      0, 1, 0};
        vt[10] = '{0, 0, 0,           1, 9, 32'h5,     9, 4, 1, 9, 0, 32'h5,  32'h22, 32'h99, 0, 0, 1};
        vt[11] = '{0, 0, 0,           0, 0, 0,         9, 7, 0, 0, 0, 32'h5,  32'hB,  32'h5,  1, 1, 1};
        vt[12] = '{0, 0, 0,           0, 0, 0,         0, 9, 1, 0, 0, 0,      32'h5,  0,      0, 0, 1};
        vt[13] = '{1, 9, 32'h9,       0, 0, 0,         9, 0, 0, 0, 0, 32'h9,  0,      32'h5,  0, 1, 0};
        vt[14] = '{1, 9, 32'h77,      0, 0, 0,         9, 3, 1, 9, 1, 32'h77, 32'h11, 32'h9,  0, 0, 0};
        vt[15] = '{0, 0, 0,           0, 0, 0,         9, 7, 0, 0, 0, 32'h77, 32'hB,  32'h77, 0, 0, 0};

        for (int k = 0; k < 16; k++) begin
            bus.we0 = vt[k].we0; bus.waddr0 = vt[k].wa0; bus.wdata0 = vt[k].wd0;
            bus.we1 = vt[k].we1; bus.waddr1 = vt[k].wa1; bus.wdata1 = vt[k].wd1;
            bus.raddr[0] = vt[k].ra0; bus.raddr[1] = vt[k].ra1;
            bus.iss_valid = vt[k].iv; bus.iss_rd = vt[k].ird; bus.flush = vt[k].fl;
            #1;
            chk($sformatf("vec%0d_rdata0", k), bus.rdata[0], vt[k].e_rd0);
            chk($sformatf("vec%0d_rdata1", k), bus.rdata[1], vt[k].e_rd1);
            chk($sformatf("vec%0d_rdata0_nobypass", k), bus_nb.rdata[0], vt[k].e_rd0_nb);
            chk($sformatf("vec%0d_rbusy0", k), bus.rbusy[0], vt[k].e_rb0);
            chk($sformatf("vec%0d_rbusy0_nobypass", k), bus_nb.rbusy[0], vt[k].e_rb0_nb);
            tick();
            chk($sformatf("vec%0d_busy_cnt", k), bus.busy_cnt, vt[k].e_cnt);
            chk($sformatf("vec%0d_busy_cnt_nobypass", k), bus_nb.busy_cnt, vt[k].e_cnt);
        end

        // Flush overriding a same-cycle issue.
        idle();
        for (int r = 1; r <= 3; r++) begin
            bus.iss_valid = 1; bus.iss_rd = AW'(r);
            tick();
            chk($sformatf("flush_issue%0d_cnt", r), bus.busy_cnt, r);
        end
        bus.iss_valid = 1; bus.iss_rd = 5'd4; bus.flush = 1;
        bus.raddr[0] = 5'd1; bus.raddr[1] = 5'd4;
        #1 chk("flush_pre_rbusy_r1", bus.rbusy[0], 1);
        tick();
        idle();
        chk("flush_cnt", bus.busy_cnt, 0);
        #1;
        chk("flush_rbusy_r1", bus.rbusy[0], 0);
        chk("flush_rbusy_r4", bus.rbusy[1], 0);
        @(negedge clk);

        // Saturation: every non-zero register busy, then drained by writes.
        for (int r = 1; r < NREGS; r++) begin
            bus.iss_valid = 1; bus.iss_rd = AW'(r);
            tick();
            chk($sformatf("sat_cnt_r%0d", r), bus.busy_cnt, r);
        end
        bus.iss_rd = 5'd0;
        tick();
        chk("sat_cnt_issue_r0", bus.busy_cnt, NREGS - 1);
        bus.iss_rd = 5'd5;
        tick();
        chk("sat_cnt_reissue", bus.busy_cnt, NREGS - 1);
        idle();
        for (int r = 1; r < NREGS; r += 2) begin
            bus.we0 = 1; bus.waddr0 = AW'(r);     bus.wdata0 = 32'(r);
            bus.we1 = 1; bus.waddr1 = AW'(r + 1); bus.wdata1 = 32'(r + 1);
            tick();
        end
        idle();
        chk("drain_cnt", bus.busy_cnt, 0);

        // Asynchronous reset asserted mid-cycle.
        bus.we0 = 1; bus.waddr0 = 5'd5; bus.wdata0 = 32'hDEADBEEF;
        bus.iss_valid = 1; bus.iss_rd = 5'd6;
        tick();
        idle();
        bus.raddr[0] = 5'd5; bus.raddr[1] = 5'd6;
        #1;
        chk("prereset_rdata_r5", bus.rdata[0], 32'hDEADBEEF);
        chk("prereset_cnt", bus.busy_cnt, 1);
        #1 rst = 0;
        #1;
        chk("midreset_rdata_r5", bus.rdata[0], 0);
        chk("midreset_rbusy_r6", bus.rbusy[1], 0);
        chk("midreset_cnt", bus.busy_cnt, 0);
        m_reset();
        @(negedge clk);
        rst = 1;
        #1 chk("postreset_rdata_r5", bus.rdata[0], 0);
        @(negedge clk);

        // Random traffic against the model.
        for (int n = 0; n < 400; n++) begin
            bus.we0 = 1'($urandom_range(0, 1)); bus.waddr0 = AW'($urandom); bus.wdata0 = $urandom;
            bus.we1 = 1'($urandom_range(0, 1)); bus.waddr1 = AW'($urandom); bus.wdata1 = $urandom;
            if ($urandom_range(0, 3) == 0) bus.waddr1 = bus.waddr0;
            bus.iss_valid = 1'($urandom_range(0, 1)); bus.iss_rd = AW'($urandom);
            bus.flush = ($urandom_range(0, 24) == 0);
            for (int i = 0; i < NRD; i++) begin
                case ($urandom_range(0, 3))
                    0: bus.raddr[i] = bus.waddr0;
                    1: bus.raddr[i] = bus.waddr1;
                    2: bus.raddr[i] = bus.iss_rd;
                    default: bus.raddr[i] = AW'($urandom);
                endcase
            end
            #1;
            for (int i = 0; i < NRD; i++) begin
                chk($sformatf("rnd%0d_rdata%0d", n, i), bus.rdata[i], m_read(bus.raddr[i], 1'b1));
                chk($sformatf("rnd%0d_rbusy%0d", n, i), bus.rbusy[i], m_rbusy(bus.raddr[i], 1'b1));
                chk($sformatf("rnd%0d_rdata%0d_nobypass", n, i), bus_nb.rdata[i], m_read(bus.raddr[i], 1'b0));
                chk($sformatf("rnd%0d_rbusy%0d_nobypass", n, i), bus_nb.rbusy[i], m_rbusy(bus.raddr[i], 1'b0));
            end
            tick();
            chk($sformatf("rnd%0d_busy_cnt", n), bus.busy_cnt, m_cnt());
            chk($sformatf("rnd%0d_busy_cnt_nobypass", n), bus_nb.busy_cnt, m_cnt());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
